// File: rtl/acc_cfg_sched.sv
// Safe-update scheduler for the acc timing unit's delay/hold configuration.
// Host writes land in a shadow register and are applied during a quiet (or timed-out) window with the result gated.
module acc_cfg_sched #(
  parameter int unsigned QUIET_UNITS   = 4,
  parameter int unsigned TIMEOUT_UNITS = 4096,
  parameter int unsigned SETTLE_CYC    = 2,
  parameter logic [15:0] DEF_DELAY     = 16'd1,
  parameter logic [15:0] DEF_HOLD      = 16'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_vld_i,
  output logic        cfg_rdy_o,
  input  logic [15:0] cfg_delay_i,
  input  logic [15:0] cfg_hold_i,
  input  logic        filter_unit_flag_i,
  input  logic        filter_acc_result_i,
  input  logic        filter_acc_flag_i,
  output logic        acc_result_gated_o,
  output logic [15:0] acc_delay_o,
  output logic [15:0] acc_hold_o,
  output logic        cfg_busy_o,
  output logic        cfg_force_o,
  input  logic        force_clr_i,
  output logic [31:0] acc_evt_cnt_o
);

  localparam logic [15:0] QUIET_LIM  = 16'(QUIET_UNITS);
  localparam logic [15:0] TO_LIM     = 16'(TIMEOUT_UNITS);
  localparam logic [15:0] SETTLE_LIM = 16'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, PEND, GATE, SETTLE} state_t;

  state_t      state;
  logic        gate;
  logic        flag_d;
  logic        unit_dirty;
  logic [15:0] shadow_delay;
  logic [15:0] shadow_hold;
  logic [15:0] quiet_cnt;
  logic [15:0] to_cnt;
  logic [15:0] settle_cnt;

  assign unit_dirty         = filter_acc_flag_i | filter_acc_result_i;
  assign acc_result_gated_o = filter_acc_result_i & ~gate;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cfg_rdy_o     <= 1'b1;
      cfg_busy_o    <= 1'b0;
      gate          <= 1'b0;
      cfg_force_o   <= 1'b0;
      acc_evt_cnt_o <= 32'd0;
      flag_d        <= 1'b0;
      acc_delay_o   <= DEF_DELAY;
      acc_hold_o    <= DEF_HOLD;
      shadow_delay  <= 16'd0;
      shadow_hold   <= 16'd0;
      quiet_cnt     <= 16'd0;
      to_cnt        <= 16'd0;
      settle_cnt    <= 16'd0;
    end else begin
      flag_d <= filter_acc_flag_i;
      if (filter_acc_flag_i && !flag_d)
        acc_evt_cnt_o <= acc_evt_cnt_o + 32'd1;
      // A timeout in the same cycle overrides this clear further down.
      if (force_clr_i)
        cfg_force_o <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_vld_i && cfg_rdy_o) begin
            shadow_delay <= cfg_delay_i;
            shadow_hold  <= cfg_hold_i;
            quiet_cnt    <= 16'd0;
            to_cnt       <= 16'd0;
            state        <= PEND;
            cfg_rdy_o    <= 1'b0;
            cfg_busy_o   <= 1'b1;
          end
        end
        PEND: begin
          if (quiet_cnt == QUIET_LIM) begin
            state <= GATE;
            gate  <= 1'b1;
          end else if (to_cnt == TO_LIM) begin
            state       <= GATE;
            gate        <= 1'b1;
            cfg_force_o <= 1'b1;
          end
          if (unit_dirty)
            quiet_cnt <= 16'd0;
          else if (filter_unit_flag_i)
            quiet_cnt <= quiet_cnt + 16'd1;
          if (filter_unit_flag_i)
            to_cnt <= to_cnt + 16'd1;
        end
        GATE: begin
          acc_delay_o <= shadow_delay;
          acc_hold_o  <= shadow_hold;
          settle_cnt  <= 16'd0;
          state       <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LIM) begin
            state      <= IDLE;
            gate       <= 1'b0;
            cfg_rdy_o  <= 1'b1;
            cfg_busy_o <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cfg_sched.sv
// Bench for acc_cfg_sched: directed scenarios plus random traffic against a timestamp-based reference model.
module tb_acc_cfg_sched;

  localparam int QU = 4;
  localparam int TU = 16;
  localparam int ST = 2;

  logic        clk_i = 1'b0;
  logic        rst_i, cfg_vld_i, filter_unit_flag_i, filter_acc_result_i, filter_acc_flag_i, force_clr_i;
  logic [15:0] cfg_delay_i, cfg_hold_i;
  logic        cfg_rdy_o, acc_result_gated_o, cfg_busy_o, cfg_force_o;
  logic [15:0] acc_delay_o, acc_hold_o;
  logic [31:0] acc_evt_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  acc_cfg_sched #(
    .QUIET_UNITS(QU), .TIMEOUT_UNITS(TU), .SETTLE_CYC(ST),
    .DEF_DELAY(16'd1), .DEF_HOLD(16'd1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_vld_i(cfg_vld_i), .cfg_rdy_o(cfg_rdy_o),
    .cfg_delay_i(cfg_delay_i), .cfg_hold_i(cfg_hold_i),
    .filter_unit_flag_i(filter_unit_flag_i), .filter_acc_result_i(filter_acc_result_i),
    .filter_acc_flag_i(filter_acc_flag_i), .acc_result_gated_o(acc_result_gated_o),
    .acc_delay_o(acc_delay_o), .acc_hold_o(acc_hold_o), .cfg_busy_o(cfg_busy_o),
    .cfg_force_o(cfg_force_o), .force_clr_i(force_clr_i), .acc_evt_cnt_o(acc_evt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: tracks the pending write and the edge numbers at which it is applied and released.
  int          edge_no = 0;
  bit          m_ready, m_pend, m_gate, m_force, m_prev_flag;
  int          m_quiet, m_units, apply_edge, release_edge;
  logic [15:0] m_sd, m_sh, m_delay, m_hold;
  logic [31:0] m_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelEdge();
    edge_no++;
    if (!rst_i) begin
      m_ready = 1; m_pend = 0; m_gate = 0; m_force = 0; m_prev_flag = 0;
      m_quiet = 0; m_units = 0; apply_edge = -1; release_edge = -1;
      m_delay = 16'd1; m_hold = 16'd1; m_cnt = 32'd0;
      return;
    end
    if (filter_acc_flag_i && !m_prev_flag) m_cnt = m_cnt + 32'd1;
    m_prev_flag = filter_acc_flag_i;
    if (force_clr_i) m_force = 0;
    if (edge_no == apply_edge) begin
      m_delay = m_sd;
      m_hold  = m_sh;
    end
    if (edge_no == release_edge) begin
      m_gate  = 0;
      m_ready = 1;
    end else if (m_ready) begin
      if (cfg_vld_i) begin
        m_sd = cfg_delay_i; m_sh = cfg_hold_i;
        m_ready = 0; m_pend = 1; m_quiet = 0; m_units = 0;
      end
    end else if (m_pend) begin
      if (m_quiet >= QU || m_units >= TU) begin
        if (m_quiet < QU) m_force = 1;
        m_pend = 0; m_gate = 1;
        apply_edge   = edge_no + 1;
        release_edge = edge_no + 1 + ST;
      end else begin
        if (filter_acc_flag_i || filter_acc_result_i) m_quiet = 0;
        else if (filter_unit_flag_i) m_quiet++;
        if (filter_unit_flag_i) m_units++;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    modelEdge();
    #1;
    checkOutput("rdy",   32'(cfg_rdy_o),   32'(m_ready));
    checkOutput("busy",  32'(cfg_busy_o),  32'(!m_ready));
    checkOutput("delay", 32'(acc_delay_o), 32'(m_delay));
    checkOutput("hold",  32'(acc_hold_o),  32'(m_hold));
    checkOutput("force", 32'(cfg_force_o), 32'(m_force));
    checkOutput("evt",   acc_evt_cnt_o,    m_cnt);
    checkOutput("gated", 32'(acc_result_gated_o), 32'(filter_acc_result_i & ~m_gate));
  endtask

  task automatic applyStimulus(input bit rst, input bit vld, input logic [15:0] d, input logic [15:0] h,
                               input bit unit, input bit res, input bit flag, input bit clr);
    rst_i = rst; cfg_vld_i = vld; cfg_delay_i = d; cfg_hold_i = h;
    filter_unit_flag_i = unit; filter_acc_result_i = res; filter_acc_flag_i = flag; force_clr_i = clr;
    stepCycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 16'd0, 16'd0, 0, 0, 0, 0);
  endtask

  task automatic hostWrite(input logic [15:0] d, input logic [15:0] h);
    bit accepted;
    accepted = 0;
    for (int i = 0; i < 300 && !accepted; i++) begin
      accepted = m_ready;
      applyStimulus(1, 1, d, h, 0, 0, 0, 0);
    end
    checkOutput("write_accept", 32'(accepted), 32'd1);
  endtask

  // Unit tick every 4 clocks; dirty_tick marks one tick carrying result=1, res_high holds result throughout.
  task automatic runTicks(input int n, input int dirty_tick, input bit res_high);
    for (int i = 1; i <= n; i++) begin
      for (int j = 0; j < 3; j++) applyStimulus(1, 0, 16'd0, 16'd0, 0, res_high, 0, 0);
      applyStimulus(1, 0, 16'd0, 16'd0, 1, res_high || (i == dirty_tick), 0, 0);
    end
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus(1, 0, 16'd0, 16'd0, 0, 0, 0, 0);
      n++;
    end while (!m_ready && n < budget);
    checkOutput("ready_wait", 32'(cfg_rdy_o), 32'd1);
  endtask

  initial begin
    rst_i = 0; cfg_vld_i = 0; cfg_delay_i = 0; cfg_hold_i = 0;
    filter_unit_flag_i = 0; filter_acc_result_i = 0; filter_acc_flag_i = 0; force_clr_i = 0;

    // Reset values
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 0, 0, 0);
    idle(1);
    checkOutput("reset_rdy", 32'(cfg_rdy_o), 32'd1);
    checkOutput("reset_delay", 32'(acc_delay_o), 32'd1);
    checkOutput("reset_hold", 32'(acc_hold_o), 32'd1);
    checkOutput("reset_busy", 32'(cfg_busy_o), 32'd0);
    checkOutput("reset_cnt", acc_evt_cnt_o, 32'd0);

    // Clean apply after four quiet ticks
    hostWrite(16'd5, 16'd3);
    runTicks(4, -1, 0);
    idle(2);
    checkOutput("t2_delay", 32'(acc_delay_o), 32'd5);
    checkOutput("t2_hold", 32'(acc_hold_o), 32'd3);
    checkOutput("t2_gated_busy", 32'(cfg_rdy_o), 32'd0);
    idle(ST);
    checkOutput("t2_rdy", 32'(cfg_rdy_o), 32'd1);

    // Dirty tick restarts the quiet count
    hostWrite(16'd8, 16'd0);
    runTicks(7, 3, 0);
    checkOutput("t3_not_yet", 32'(acc_delay_o), 32'd5);
    waitReady(40);
    checkOutput("t3_delay", 32'(acc_delay_o), 32'd8);
    checkOutput("t3_hold_zero", 32'(acc_hold_o), 32'd0);
    checkOutput("t3_noforce", 32'(cfg_force_o), 32'd0);

    // Result stuck high forces apply at the timeout
    hostWrite(16'd0, 16'd7);
    runTicks(TU, -1, 1);
    waitReady(40);
    checkOutput("t4_force", 32'(cfg_force_o), 32'd1);
    checkOutput("t4_delay", 32'(acc_delay_o), 32'd0);
    applyStimulus(1, 0, 16'd0, 16'd0, 0, 0, 0, 1);
    checkOutput("t4_force_clr", 32'(cfg_force_o), 32'd0);

    // Second write held while busy
    hostWrite(16'd4, 16'd4);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'd9, 16'd2, 0, 0, 0, 0);
    checkOutput("t5_hold_first", 32'(acc_delay_o), 32'd0);
    runTicks(4, -1, 0);
    waitReady(40);
    checkOutput("t5_first", 32'(acc_delay_o), 32'd4);
    hostWrite(16'd9, 16'd2);
    runTicks(4, -1, 0);
    waitReady(40);
    checkOutput("t5_second", 32'(acc_delay_o), 32'd9);

    // Event count, then reset during PEND
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 16'd0, 16'd0, 0, 0, 1, 0);
      applyStimulus(1, 0, 16'd0, 16'd0, 0, 0, 1, 0);
      idle(2);
    end
    checkOutput("t6_cnt", acc_evt_cnt_o, 32'd3);
    hostWrite(16'd33, 16'd44);
    runTicks(2, -1, 0);
    applyStimulus(0, 0, 16'd0, 16'd0, 0, 0, 0, 0);
    idle(12);
    checkOutput("t6_delay", 32'(acc_delay_o), 32'd1);
    checkOutput("t6_cnt_rst", acc_evt_cnt_o, 32'd0);
    checkOutput("t6_rdy", 32'(cfg_rdy_o), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d, h;
      d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      h = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      applyStimulus($urandom_range(0, 799) != 0, $urandom_range(0, 5) == 0, d, h,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 14) == 0, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
